// File: rtl/imem_loader.sv
// imem_loader: boot-time loader for the instruction memory.
// Parses a framed byte stream (16-bit word count, little-endian data words,
// XOR checksum), writes each assembled word to consecutive addresses, holds
// the CPU while loading and reports done or a classified error.
module imem_loader #(
    parameter int          ADDR_W       = 11,
    parameter int          DEPTH        = 2048,
    parameter logic [23:0] IDLE_TIMEOUT = 24'd5_000_000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [31:0]       wr_data,
    output logic              cpu_hold,
    output logic              done,
    output logic              error,
    output logic [1:0]        err_code,
    output logic [ADDR_W:0]   words_loaded
);

    typedef enum logic [2:0] {
        S_IDLE, S_HDR0, S_HDR1, S_CHK_N, S_DATA, S_CSUM, S_DONE, S_ERR
    } state_t;

    localparam logic [16:0] DEPTH_L = 17'(DEPTH);

    state_t state_reg, state_next;

    logic [15:0]       count_reg, count_next;
    logic [1:0]        lane_reg, lane_next;
    logic [23:0]       word_reg, word_next;       // bytes 0..2 of the word being built
    logic [7:0]        csum_reg, csum_next;
    logic [23:0]       tmo_reg, tmo_next;
    logic              pend_reg, pend_next;       // assembled word waiting to be written
    logic [31:0]       pend_data_reg, pend_data_next;
    logic              wr_en_reg, wr_en_next;
    logic [ADDR_W-1:0] wr_addr_reg, wr_addr_next;
    logic [31:0]       wr_data_reg, wr_data_next;
    logic              hold_reg, hold_next;
    logic              done_reg, done_next;
    logic              error_reg, error_next;
    logic [1:0]        err_code_reg, err_code_next;
    logic [ADDR_W:0]   words_reg, words_next;

    logic        n_big, n_zero, tmo_active, timeout_hit, accept_data, last_word, load_begin;
    logic [23:0] tmo_inc;

    // Decode helpers shared by the next-state and datapath logic
    always_comb begin
        n_big       = {1'b0, count_reg} > DEPTH_L;
        n_zero      = (count_reg == 16'd0);
        tmo_inc     = tmo_reg + 24'd1;
        tmo_active  = (state_reg == S_HDR0) || (state_reg == S_HDR1) ||
                      (state_reg == S_DATA) || (state_reg == S_CSUM);
        // An arriving byte always beats an expiring timer
        timeout_hit = tmo_active && !rx_valid && (IDLE_TIMEOUT != 24'd0) &&
                      (tmo_inc == IDLE_TIMEOUT);
        accept_data = rx_valid && ((state_reg == S_DATA) ||
                      ((state_reg == S_CHK_N) && !n_big && !n_zero));
        last_word   = (17'(words_reg) + 17'd1) == {1'b0, count_reg};
        load_begin  = start && ((state_reg == S_IDLE) || (state_reg == S_DONE) ||
                      (state_reg == S_ERR));
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_reg <= S_IDLE;
        else      state_reg <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE, S_DONE, S_ERR: if (start) state_next = S_HDR0;
            S_HDR0:  if (rx_valid) state_next = S_HDR1;
                     else if (timeout_hit) state_next = S_ERR;
            S_HDR1:  if (rx_valid) state_next = S_CHK_N;
                     else if (timeout_hit) state_next = S_ERR;
            S_CHK_N: if (n_big) state_next = S_ERR;
                     else if (n_zero) state_next = S_CSUM;
                     else state_next = S_DATA;
            S_DATA:  if (rx_valid && (lane_reg == 2'd3) && last_word) state_next = S_CSUM;
                     else if (timeout_hit) state_next = S_ERR;
            S_CSUM:  if (rx_valid) state_next = (rx_data == csum_reg) ? S_DONE : S_ERR;
                     else if (timeout_hit) state_next = S_ERR;
            default: state_next = S_IDLE;
        endcase
    end

    // Output and datapath next values
    always_comb begin
        count_next     = count_reg;
        lane_next      = lane_reg;
        word_next      = word_reg;
        csum_next      = csum_reg;
        tmo_next       = tmo_reg;
        pend_next      = 1'b0;
        pend_data_next = pend_data_reg;
        wr_en_next     = 1'b0;
        wr_addr_next   = wr_addr_reg;
        wr_data_next   = wr_data_reg;
        done_next      = done_reg;
        error_next     = error_reg;
        err_code_next  = err_code_reg;
        words_next     = words_reg;

        // Issue the word assembled on the previous edge
        if (pend_reg) begin
            wr_en_next   = 1'b1;
            wr_addr_next = words_reg[ADDR_W-1:0];
            wr_data_next = pend_data_reg;
            words_next   = words_reg + (ADDR_W+1)'(1);
        end

        if (state_reg == S_HDR0 && rx_valid) count_next[7:0]  = rx_data;
        if (state_reg == S_HDR1 && rx_valid) count_next[15:8] = rx_data;

        if (accept_data) begin
            csum_next = csum_reg ^ rx_data;
            case (lane_reg)
                2'd0:    word_next[7:0]   = rx_data;
                2'd1:    word_next[15:8]  = rx_data;
                2'd2:    word_next[23:16] = rx_data;
                default: begin
                    pend_next      = 1'b1;
                    pend_data_next = {rx_data, word_reg};
                end
            endcase
            lane_next = lane_reg + 2'd1;
        end

        if ((tmo_active && rx_valid) || accept_data) tmo_next = 24'd0;
        else if (tmo_active)                         tmo_next = tmo_inc;

        if (state_reg == S_CSUM && state_next == S_DONE) done_next = 1'b1;
        if (state_next == S_ERR && state_reg != S_ERR) begin
            error_next = 1'b1;
            if (state_reg == S_CHK_N)                 err_code_next = 2'b01;
            else if (state_reg == S_CSUM && rx_valid) err_code_next = 2'b10;
            else                                      err_code_next = 2'b11;
        end

        if (load_begin) begin
            done_next     = 1'b0;
            error_next    = 1'b0;
            err_code_next = 2'b00;
            words_next    = '0;
            lane_next     = 2'd0;
            csum_next     = 8'd0;
            tmo_next      = 24'd0;
            pend_next     = 1'b0;
        end

        hold_next = (state_next == S_HDR0) || (state_next == S_HDR1) ||
                    (state_next == S_CHK_N) || (state_next == S_DATA) ||
                    (state_next == S_CSUM);
    end

    // Datapath and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_reg     <= '0;
            lane_reg      <= '0;
            word_reg      <= '0;
            csum_reg      <= '0;
            tmo_reg       <= '0;
            pend_reg      <= 1'b0;
            pend_data_reg <= '0;
            wr_en_reg     <= 1'b0;
            wr_addr_reg   <= '0;
            wr_data_reg   <= '0;
            hold_reg      <= 1'b0;
            done_reg      <= 1'b0;
            error_reg     <= 1'b0;
            err_code_reg  <= 2'b00;
            words_reg     <= '0;
        end else begin
            count_reg     <= count_next;
            lane_reg      <= lane_next;
            word_reg      <= word_next;
            csum_reg      <= csum_next;
            tmo_reg       <= tmo_next;
            pend_reg      <= pend_next;
            pend_data_reg <= pend_data_next;
            wr_en_reg     <= wr_en_next;
            wr_addr_reg   <= wr_addr_next;
            wr_data_reg   <= wr_data_next;
            hold_reg      <= hold_next;
            done_reg      <= done_next;
            error_reg     <= error_next;
            err_code_reg  <= err_code_next;
            words_reg     <= words_next;
        end
    end

    assign wr_en        = wr_en_reg;
    assign wr_addr      = wr_addr_reg;
    assign wr_data      = wr_data_reg;
    assign cpu_hold     = hold_reg;
    assign done         = done_reg;
    assign error        = error_reg;
    assign err_code     = err_code_reg;
    assign words_loaded = words_reg;

endmodule
